// File: rtl/mem_io_capture.sv
// Captures each distinct in-window CPU store as an {addr, data} entry in a show-ahead FIFO.
// Latency: entry visible one posedge after the store. No backpressure: when full, stores are dropped and counted.

module mem_io_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdat,
    output logic [WIDTH-1:0]           rdat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rdat    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= wdat;
    end

endmodule

module mem_io_capture #(
    parameter int         DEPTH   = 8,
    parameter logic [7:0] ADDR_LO = 8'h00,
    parameter logic [7:0] ADDR_HI = 8'hFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       MemRW_IO,
    input  logic [7:0]                 MemAddr_IO,
    input  logic [15:0]                MemD_IO,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [7:0]                 rd_addr,
    output logic [15:0]                rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } entry_t;

    logic [24:0] prev;
    logic [24:0] cur;
    logic [8:0]  lo_diff;
    logic [8:0]  hi_diff;
    logic        in_win;
    logic        wr_evt;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        drop;
    entry_t      wr_entry;
    entry_t      head;

    assign cur = {MemRW_IO, MemAddr_IO, MemD_IO};

    // Window test via borrow bits so a window edge at 0 or 255 is not a constant compare.
    assign lo_diff = {1'b0, MemAddr_IO} - {1'b0, ADDR_LO};
    assign hi_diff = {1'b0, ADDR_HI} - {1'b0, MemAddr_IO};
    assign in_win  = !lo_diff[8] && !hi_diff[8];

    assign wr_evt   = MemRW_IO && in_win && (cur != prev);
    assign pop      = rd_valid && rd_ready;
    assign drop     = wr_evt && full && !pop;
    assign push     = wr_evt && !drop;
    assign wr_entry = '{addr: MemAddr_IO, data: MemD_IO};

    mem_io_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdat  (wr_entry),
        .rdat  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign rd_valid = !empty;
    assign rd_addr  = rd_valid ? head.addr : 8'h00;
    assign rd_data  = rd_valid ? head.data : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'h00;
        end else begin
            prev <= cur;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_capture.sv
// Directed bench for mem_io_capture: vector table plus hand-written multi-cycle sequences.
module tb_mem_io_capture;

    logic        clk;
    logic        rst;
    logic        MemRW_IO;
    logic [7:0]  MemAddr_IO;
    logic [15:0] MemD_IO;
    logic        rd_ready;

    logic        rd_valid;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    logic        w_rd_valid;
    logic [7:0]  w_rd_addr;
    logic [15:0] w_rd_data;
    logic [3:0]  w_count;
    logic        w_overflow;
    logic [7:0]  w_drop_cnt;

    int errors = 0;
    int checks = 0;

    mem_io_capture #(.DEPTH(8), .ADDR_LO(8'h00), .ADDR_HI(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRW_IO   (MemRW_IO),
        .MemAddr_IO (MemAddr_IO),
        .MemD_IO    (MemD_IO),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    mem_io_capture #(.DEPTH(8), .ADDR_LO(8'h80), .ADDR_HI(8'h8F)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .MemRW_IO   (MemRW_IO),
        .MemAddr_IO (MemAddr_IO),
        .MemD_IO    (MemD_IO),
        .rd_ready   (rd_ready),
        .rd_valid   (w_rd_valid),
        .rd_addr    (w_rd_addr),
        .rd_data    (w_rd_data),
        .count      (w_count),
        .overflow   (w_overflow),
        .drop_cnt   (w_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [7:0]  a;
        logic [15:0] d;
        logic        rdy;
        logic        vld;
        logic [7:0]  ea;
        logic [15:0] ed;
        int          ecnt;
    } vec_t;

    vec_t vecs[16];

    task automatic drive(input logic rw, input logic [7:0] a, input logic [15:0] d, input logic rdy);
        MemRW_IO   = rw;
        MemAddr_IO = a;
        MemD_IO    = d;
        rd_ready   = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(1'b0, 8'h00, 16'h0000, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic check(input string name, input logic vld, input logic [7:0] ea,
                         input logic [15:0] ed, input int ecnt, input logic eovf, input int edrop);
        checks++;
        if (rd_valid !== vld || rd_addr !== ea || rd_data !== ed || count !== 4'(ecnt)
            || overflow !== eovf || drop_cnt !== 8'(edrop)) begin
            errors++;
            $display("FAIL %s: got vld=%0b addr=%h data=%h count=%0d ovf=%0b drop=%0d, want vld=%0b addr=%h data=%h count=%0d ovf=%0b drop=%0d",
                     name, rd_valid, rd_addr, rd_data, count, overflow, drop_cnt,
                     vld, ea, ed, ecnt, eovf, edrop);
        end
    endtask

    task automatic check_w(input string name, input logic vld, input logic [7:0] ea,
                           input logic [15:0] ed, input int ecnt);
        checks++;
        if (w_rd_valid !== vld || w_rd_addr !== ea || w_rd_data !== ed || w_count !== 4'(ecnt)) begin
            errors++;
            $display("FAIL %s: got vld=%0b addr=%h data=%h count=%0d, want vld=%0b addr=%h data=%h count=%0d",
                     name, w_rd_valid, w_rd_addr, w_rd_data, w_count, vld, ea, ed, ecnt);
        end
    endtask

    initial begin
        // single write held 3 cycles, then pop
        vecs[0]  = '{1'b1, 8'h20, 16'h1234, 1'b0, 1'b1, 8'h20, 16'h1234, 1};
        vecs[1]  = '{1'b1, 8'h20, 16'h1234, 1'b0, 1'b1, 8'h20, 16'h1234, 1};
        vecs[2]  = '{1'b1, 8'h20, 16'h1234, 1'b0, 1'b1, 8'h20, 16'h1234, 1};
        vecs[3]  = '{1'b0, 8'h20, 16'h1234, 1'b0, 1'b1, 8'h20, 16'h1234, 1};
        vecs[4]  = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 0};
        vecs[5]  = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 0};
        // change detection on a held strobe
        vecs[6]  = '{1'b1, 8'h10, 16'h0001, 1'b0, 1'b1, 8'h10, 16'h0001, 1};
        vecs[7]  = '{1'b1, 8'h10, 16'h0002, 1'b0, 1'b1, 8'h10, 16'h0001, 2};
        vecs[8]  = '{1'b1, 8'h10, 16'h0002, 1'b0, 1'b1, 8'h10, 16'h0001, 2};
        vecs[9]  = '{1'b1, 8'h10, 16'h0003, 1'b0, 1'b1, 8'h10, 16'h0001, 3};
        vecs[10] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h10, 16'h0002, 2};
        vecs[11] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h10, 16'h0003, 1};
        vecs[12] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 0};
        // push into empty with rd_ready high, then push+pop at count 1
        vecs[13] = '{1'b1, 8'h30, 16'h5555, 1'b1, 1'b1, 8'h30, 16'h5555, 1};
        vecs[14] = '{1'b1, 8'h31, 16'h6666, 1'b1, 1'b1, 8'h31, 16'h6666, 1};
        vecs[15] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 0};

        rst = 1'b1;
        drive(1'b0, 8'h00, 16'h0000, 1'b0);
        repeat (2) tick();
        check("reset", 1'b0, 8'h00, 16'h0000, 0, 1'b0, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rw, vecs[i].a, vecs[i].d, vecs[i].rdy);
            tick();
            check($sformatf("vec%0d", i), vecs[i].vld, vecs[i].ea, vecs[i].ed, vecs[i].ecnt, 1'b0, 0);
        end

        // address window
        do_reset();
        drive(1'b1, 8'h7F, 16'h1111, 1'b0); tick();
        drive(1'b1, 8'h80, 16'h2222, 1'b0); tick();
        drive(1'b1, 8'h8F, 16'h3333, 1'b0); tick();
        drive(1'b1, 8'h90, 16'h4444, 1'b0); tick();
        drive(1'b0, 8'h00, 16'h0000, 1'b0); tick();
        check_w("win_head", 1'b1, 8'h80, 16'h2222, 2);
        check("win_full_range", 1'b1, 8'h7F, 16'h1111, 4, 1'b0, 0);
        drive(1'b0, 8'h00, 16'h0000, 1'b1); tick();
        check_w("win_second", 1'b1, 8'h8F, 16'h3333, 1);

        // overflow, full push+pop, drain, saturation
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(i), 16'(16'hA000 + i), 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 16'h0000, 1'b0); tick();
        check("ovf_full", 1'b1, 8'h00, 16'hA000, 8, 1'b1, 2);
        drive(1'b1, 8'h55, 16'hCAFE, 1'b1); tick();
        check("full_pushpop", 1'b1, 8'h01, 16'hA001, 8, 1'b1, 2);
        for (int i = 0; i < 8; i++) begin
            if (i < 7)
                check($sformatf("drain%0d", i), 1'b1, 8'(i + 1), 16'(16'hA001 + i), 8 - i, 1'b1, 2);
            else
                check("drain_last", 1'b1, 8'h55, 16'hCAFE, 1, 1'b1, 2);
            drive(1'b0, 8'h00, 16'h0000, 1'b1);
            tick();
        end
        check("drained", 1'b0, 8'h00, 16'h0000, 0, 1'b1, 2);
        for (int i = 0; i < 308; i++) begin
            drive(1'b1, 8'(i), 16'(i), 1'b0);
            tick();
            if (i == 9)
                check("refill_drop", 1'b1, 8'h00, 16'h0000, 8, 1'b1, 4);
        end
        drive(1'b0, 8'h00, 16'h0000, 1'b0); tick();
        check("drop_sat", 1'b1, 8'h00, 16'h0000, 8, 1'b1, 255);

        // pointer wrap with steady push+pop
        do_reset();
        drive(1'b1, 8'h40, 16'h0000, 1'b0); tick();
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 8'(8'h40 + k), 16'(k), 1'b1);
            tick();
            check($sformatf("wrap%0d", k), 1'b1, 8'(8'h40 + k), 16'(k), 1, 1'b0, 0);
        end

        // reset mid-operation with a coincident write
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 8'(i), 16'(16'h0B00 + i), 1'b0);
            tick();
        end
        repeat (3) begin
            drive(1'b0, 8'h00, 16'h0000, 1'b1);
            tick();
        end
        check("pre_rst", 1'b1, 8'h03, 16'h0B03, 5, 1'b1, 1);
        rst = 1'b1;
        drive(1'b1, 8'h77, 16'h7777, 1'b0);
        tick();
        check("mid_rst", 1'b0, 8'h00, 16'h0000, 0, 1'b0, 0);
        rst = 1'b0;
        drive(1'b1, 8'h01, 16'hBEEF, 1'b0); tick();
        drive(1'b0, 8'h00, 16'h0000, 1'b0); tick();
        check("post_rst", 1'b1, 8'h01, 16'hBEEF, 1, 1'b0, 0);
        drive(1'b0, 8'h00, 16'h0000, 1'b1); tick();
        check("post_rst_pop", 1'b0, 8'h00, 16'h0000, 0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
